// File: rtl/pool_seq_ctrl.sv
// Sequencer for the 2x2 stride-2 max-pool stage: walks channel/row/column, fetches each
// window over four read cycles, writes the signed max, and drives the cycle-counter start/done.
module pool_seq_ctrl #(
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32,
  parameter int unsigned CH     = 3,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_go,
  output logic                     o_in_rd_en,
  output logic [ADDR_W-1:0]        o_in_rd_addr,
  input  logic signed [DATA_W-1:0] i_in_rd_data,
  output logic                     o_out_wr_en,
  output logic [ADDR_W-1:0]        o_out_wr_addr,
  output logic signed [DATA_W-1:0] o_out_wr_data,
  output logic                     o_start,
  output logic                     o_done
);

  localparam int unsigned XN = IMG_W / 2;
  localparam int unsigned RN = IMG_H / 2;
  localparam int unsigned XW = (XN > 1) ? $clog2(XN) : 1;
  localparam int unsigned RW = (RN > 1) ? $clog2(RN) : 1;
  localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [XW-1:0]     XLast      = XW'(XN - 1);
  localparam logic [RW-1:0]     RLast      = RW'(RN - 1);
  localparam logic [CW-1:0]     CLast      = CW'(CH - 1);
  localparam logic [ADDR_W-1:0] InChStride  = ADDR_W'(IMG_H * IMG_W);
  localparam logic [ADDR_W-1:0] InRowStride = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] OutChStride = ADDR_W'(RN * XN);
  localparam logic [ADDR_W-1:0] OutRowStride = ADDR_W'(XN);

  typedef enum logic [1:0] {StIdle, StFetch, StWrite, StDone} state_e;

  state_e                   r_state;
  logic [1:0]               r_phase;
  logic [XW-1:0]            r_x;
  logic [RW-1:0]            r_r;
  logic [CW-1:0]            r_c;
  logic signed [DATA_W-1:0] r_acc;
  logic                     r_rd_en;
  logic                     r_wr_en;
  logic                     r_start;
  logic                     r_done;

  logic signed [DATA_W-1:0] w_max;
  logic                     w_last;
  logic [ADDR_W-1:0]        w_in_addr;
  logic [ADDR_W-1:0]        w_out_addr;

  // Operands are both declared signed, so this is a two's-complement compare.
  assign w_max  = (i_in_rd_data > r_acc) ? i_in_rd_data : r_acc;
  assign w_last = (r_x == XLast) && (r_r == RLast) && (r_c == CLast);

  // {r, p[1]} is the input row 2r+p[1]; {x, p[0]} is the input column 2x+p[0].
  assign w_in_addr  = ADDR_W'(r_c) * InChStride
                    + ADDR_W'({r_r, r_phase[1]}) * InRowStride
                    + ADDR_W'({r_x, r_phase[0]});
  assign w_out_addr = ADDR_W'(r_c) * OutChStride + ADDR_W'(r_r) * OutRowStride + ADDR_W'(r_x);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_phase <= 2'd0;
      r_x     <= '0;
      r_r     <= '0;
      r_c     <= '0;
      r_acc   <= '0;
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (i_go) begin
            r_state <= StFetch;
            r_phase <= 2'd0;
            r_x     <= '0;
            r_r     <= '0;
            r_c     <= '0;
            r_rd_en <= 1'b1;
            r_wr_en <= 1'b0;
            r_start <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        StFetch: begin
          r_phase <= r_phase + 2'd1;
          // Data returned this cycle belongs to the previous phase.
          if (r_phase == 2'd1) begin
            r_acc <= i_in_rd_data;
          end else if (r_phase[1]) begin
            r_acc <= w_max;
          end
          if (r_phase == 2'd3) begin
            r_state <= StWrite;
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b1;
          end
        end
        StWrite: begin
          r_wr_en <= 1'b0;
          if (r_x == XLast) begin
            r_x <= '0;
            if (r_r == RLast) begin
              r_r <= '0;
              r_c <= r_c + CW'(1);
            end else begin
              r_r <= r_r + RW'(1);
            end
          end else begin
            r_x <= r_x + XW'(1);
          end
          if (w_last) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end else begin
            r_state <= StFetch;
            r_rd_en <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_in_rd_en    = r_rd_en;
  assign o_in_rd_addr  = r_rd_en ? w_in_addr : '0;
  assign o_out_wr_en   = r_wr_en;
  assign o_out_wr_addr = r_wr_en ? w_out_addr : '0;
  assign o_out_wr_data = r_wr_en ? w_max : '0;
  assign o_start       = r_start;
  assign o_done        = r_done;

endmodule

// File: tb/tb_pool_seq_ctrl.sv
// Scoreboard bench for pool_seq_ctrl on a 4x4x2 map: a reference model queues expected reads
// and writes, and a negedge monitor pops and compares whatever the DUT presents.
module tb_pool_seq_ctrl;
  localparam int W = 4, H = 4, C = 2, DW = 8, AW = 16;
  localparam int N = C * (H / 2) * (W / 2);
  localparam int MEMN = C * H * W;

  logic clk = 1'b0, rst = 1'b1, go = 1'b0;
  logic rd_en, wr_en, start, done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic signed [DW-1:0] rd_data, wr_data;

  pool_seq_ctrl #(.IMG_W(W), .IMG_H(H), .CH(C), .DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_go(go),
    .o_in_rd_en(rd_en), .o_in_rd_addr(rd_addr), .i_in_rd_data(rd_data),
    .o_out_wr_en(wr_en), .o_out_wr_addr(wr_addr), .o_out_wr_data(wr_data),
    .o_start(start), .o_done(done)
  );

  always #5 clk = ~clk;

  logic signed [DW-1:0] mem [MEMN];
  // One-cycle read latency; junk when not strobed so stale-data use shows up.
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr[4:0]] : DW'($urandom);

  int tests = 0, fails = 0, cyc = 0, act = 0, n_wr = 0, first_wr = -1;
  int rdq[$], wa_q[$], wd_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // Monitor: every strobe is matched against the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (start && !done) act++;
      if (rd_en) begin
        if (rdq.size() == 0) flag("rd_extra");
        else check("rd_addr", int'(rd_addr), rdq.pop_front());
      end
      if (wr_en) begin
        n_wr++;
        if (first_wr < 0) first_wr = cyc;
        if (wa_q.size() == 0) flag("wr_extra");
        else begin
          check("wr_addr", int'(wr_addr), wa_q.pop_front());
          check("wr_data", int'(wr_data), wd_q.pop_front());
        end
      end
    end
  end

  // Reference: max over each 2x2 window in channel/row/column order.
  task automatic build_model();
    for (int c = 0; c < C; c++)
      for (int r = 0; r < H / 2; r++)
        for (int x = 0; x < W / 2; x++) begin
          int m;
          m = -1000000;
          for (int p = 0; p < 4; p++) begin
            int a;
            a = c * H * W + (2 * r + p / 2) * W + 2 * x + p % 2;
            rdq.push_back(a);
            if (int'(mem[a]) > m) m = int'(mem[a]);
          end
          wa_q.push_back(c * (H / 2) * (W / 2) + r * (W / 2) + x);
          wd_q.push_back(m);
        end
  endtask

  task automatic run_once(input bit busy);
    int g, a0, w0, k;
    @(negedge clk);
    go = 1'b1;
    g = cyc + 1;
    first_wr = -1;
    a0 = act;
    w0 = n_wr;
    @(negedge clk);
    go = 1'b0;
    k = 1;
    check("done_low_c1", int'(done), 0);
    check("start_c1", int'(start), 1);
    while (!done && k < 1000) begin
      if (busy) go = 1'($urandom_range(0, 1));
      @(negedge clk);
      k++;
    end
    go = 1'b0;
    if (!done) flag("done_timeout");
    check("done_latency", k - 1, 5 * N);
    check("first_wr_cycle", first_wr - g + 1, 5);
    check("active_cycles", act - a0, 5 * N);
    check("write_count", n_wr - w0, N);
    check("rdq_drained", rdq.size(), 0);
    check("wrq_drained", wa_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, int'(rd_en), 0);
    check({tag, "_rd_addr"}, int'(rd_addr), 0);
    check({tag, "_wr_en"}, int'(wr_en), 0);
    check({tag, "_wr_addr"}, int'(wr_addr), 0);
    check({tag, "_wr_data"}, int'(wr_data), 0);
    check({tag, "_start"}, int'(start), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int base, a0, w0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Ordered input: expected data 5,7,13,15,21,23,29,31 at addresses 0..7.
    for (int i = 0; i < MEMN; i++) mem[i] = DW'(i);
    base = act;
    build_model();
    run_once(1'b0);

    // Hold in DONE, then restart with identical contents.
    a0 = act;
    repeat (10) @(negedge clk);
    check("hold_done", int'(done), 1);
    check("hold_start", int'(start), 1);
    check("hold_no_count", act - a0, 0);
    build_model();
    run_once(1'b0);
    check("cumulative_count", act - base, 2 * 5 * N);

    // Random maps with signed-extreme windows; second run hammers go while busy.
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < MEMN; i++) mem[i] = DW'($urandom);
      mem[0] = -8'sd128; mem[1] = -8'sd1;   mem[4] = -8'sd128; mem[5] = -8'sd128;
      mem[2] = 8'sd127;  mem[3] = -8'sd128; mem[6] = 8'sd0;    mem[7] = 8'sd0;
      build_model();
      run_once(it == 1);
    end

    // Reset during cycle 12 of a run: two writes done, everything zero after.
    for (int i = 0; i < MEMN; i++) mem[i] = DW'($urandom);
    build_model();
    @(negedge clk);
    go = 1'b1;
    w0 = n_wr;
    @(negedge clk);
    go = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    check("midreset_writes", n_wr - w0, 2);
    rst = 1'b0;
    rdq.delete();
    wa_q.delete();
    wd_q.delete();
    repeat (3) @(negedge clk);
    check("stays_idle", int'(start), 0);
    build_model();
    run_once(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
